controller: RTL and testbench
=============================

# controller

Hardwired multicycle control unit for the 16-bit accumulator-less CPU. It sequences instruction fetch, decode and execute. Each cycle it drives the datapath load enables, bus tri-state enables, ALU function select, register select and memory read/write strobe. Inputs are the current instruction register contents (`isr`) and the status flags (`sreg`).

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `isr` in 16: instruction register contents.
  - Fields: op=[15:12], rd=[11:9], rs=[8:6], f=[5:3], cond=[11:9].
- `sreg` in 4: flags {V,N,C,Z} = [3:0].
- `funsel` out 3: ALU function; Z = ALU(Y, bus).
  - 000 PASS bus, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 INC bus, 111 DEC bus.
- Load enables, out 1 each: `lsp` SP←Z; `lpc` PC←Z; `lmdr` MDR load; `lmar` MAR load; `lisr` ISR←Z; `ly` Y←bus; `wrr` R[rsel]←Z.
- `mrw` out 1: 1 = memory write M[MAR]←MDR, 0 = read.
- `rsel` out 3: register-file select (read and write).
- MAR source, out 1 each: `spmar` SP, `pcmar` PC, neither = Z.
- MDR source, out 1 each: `mdrz` Z, `mdrm` memory.
- Bus drivers, out 1 each: `tr` R[rsel], `tsp`, `tpc`, `tmdr`, `tisr`.
  - `tisr` drives sign-extended isr[8:0].

## Operation
- Outputs are decoded combinationally from the current state, `isr` and `sreg`.
- Unlisted outputs are 0 in every state.
- At most one bus driver is asserted per cycle.
- Fetch sequence:
  - F0: pcmar, lmar.
  - F1: mdrm, lmdr; also tpc, INC, lpc.
  - F2: tmdr, PASS, lisr, then dispatch on the new op.
- Branch condition = sreg[cond[10:9]] XOR cond[11]. It is sampled in F2.
- Execute steps E0..E5 per op; the last step returns to F0:
  - 0000 ALU: E0 rsel=rs,tr,ly; E1 rsel=rd,tr,funsel=f,wrr.
  - 0110 LOAD: E0 rsel=rs,tr,PASS,lmar; E1 mdrm,lmdr; E2 tmdr,PASS,rsel=rd,wrr.
  - 0111 STORE: E0 as LOAD; E1 rsel=rd,tr,PASS,mdrz,lmdr; E2 mrw.
  - 1001 PUSH: E0 tsp,DEC,lsp; E1 spmar,lmar; E2 rsel=rd,tr,PASS,mdrz,lmdr; E3 mrw.
  - 1010 RET: E0 spmar,lmar; E1 mdrm,lmdr; E2 tsp,INC,lsp; E3 tmdr,PASS,lpc.
  - 1011 POP: as RET, but E3 is tmdr,PASS,rsel=rd,wrr.
  - 1100 JMPc, condition true: E0 tpc,ly; E1 tisr,ADD,lpc.
  - 1101 CALLc, condition true: E0 tsp,DEC,lsp; E1 spmar,lmar; E2 tpc,PASS,mdrz,lmdr; E3 mrw; E4 tpc,ly; E5 tisr,ADD,lpc.
  - JMPc/CALLc with condition false, and all other opcodes (NOP): F2 → F0.
- `rsel` is 0 when unused. `funsel` is PASS (000) when unused.

## Timing
- `reset` low: state←F0 asynchronously. All outputs are forced to 0 while `reset` is low, including pcmar and lmar.
- First active cycle after `reset` rises is F0.
- Latency in cycles, including fetch:
  - ALU 5; LOAD/STORE 6; PUSH/RET/POP 7.
  - JMP taken 5; CALL taken 9; not-taken/NOP 3.
- `isr` is stable from the cycle after F2 until F0.
- `sreg` changes after F2 do not alter the taken path.
- Reset mid-instruction aborts it immediately. No partial write completes after reset asserts.

## Structure
- Shared package holds:
  - opcode constants;
  - funsel codes;
  - state enum (F0,F1,F2,E0..E5);
  - isr field bit positions.
- One small combinational sub-module, `cond_eval`: (cond, sreg) → take.
- The FSM and output decode stay in `controller`.

## Test plan
- isr=1100_001_000000000, sreg=0, release reset: F0,F1,F2 (lisr high in cycle 3), then F0 again. Never lpc with tisr.
- isr=1101_101_000000000, sreg=0 (condition true):
  - E0 lsp+tsp+funsel=111;
  - E3 mrw=1;
  - E5 tisr+lpc+funsel=001;
  - cycle 10 is F0.
- isr=0000_000_011_110_000:
  - E0 rsel=3, tr, ly;
  - E1 rsel=0, tr, funsel=110, wrr;
  - exactly one wrr pulse per instruction.
- isr=1010_0000_0000_0000 (RET): spmar+lmar, then mdrm+lmdr, then tsp+INC+lsp, then tmdr+lpc.
- isr=1001_000_011110000 (PUSH) with reset pulled low during E2: all outputs 0 at once. After release, fetch restarts at F0 with pcmar=1.
- Every cycle of every test: at most one of tr/tsp/tpc/tmdr/tisr is high; `mrw` is never high together with `mdrm`.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared constants for the multicycle control unit: opcodes, ALU codes, states,
// instruction field positions and the per-cycle control word.
package controller_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [3:0] OP_ALU   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;
    localparam logic [3:0] OP_PUSH  = 4'b1001;
    localparam logic [3:0] OP_RET   = 4'b1010;
    localparam logic [3:0] OP_POP   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_CALL  = 4'b1101;

    localparam logic [2:0] FN_PASS = 3'b000;
    localparam logic [2:0] FN_ADD  = 3'b001;
    localparam logic [2:0] FN_SUB  = 3'b010;
    localparam logic [2:0] FN_AND  = 3'b011;
    localparam logic [2:0] FN_OR   = 3'b100;
    localparam logic [2:0] FN_XOR  = 3'b101;
    localparam logic [2:0] FN_INC  = 3'b110;
    localparam logic [2:0] FN_DEC  = 3'b111;

    localparam logic [STATE_W-1:0] S_F0 = 4'd0;
    localparam logic [STATE_W-1:0] S_F1 = 4'd1;
    localparam logic [STATE_W-1:0] S_F2 = 4'd2;
    localparam logic [STATE_W-1:0] S_E0 = 4'd3;
    localparam logic [STATE_W-1:0] S_E1 = 4'd4;
    localparam logic [STATE_W-1:0] S_E2 = 4'd5;
    localparam logic [STATE_W-1:0] S_E3 = 4'd6;
    localparam logic [STATE_W-1:0] S_E4 = 4'd7;
    localparam logic [STATE_W-1:0] S_E5 = 4'd8;

    localparam int unsigned OP_HI   = 15;
    localparam int unsigned OP_LO   = 12;
    localparam int unsigned RD_HI   = 11;
    localparam int unsigned RD_LO   = 9;
    localparam int unsigned RS_HI   = 8;
    localparam int unsigned RS_LO   = 6;
    localparam int unsigned F_HI    = 5;
    localparam int unsigned F_LO    = 3;
    localparam int unsigned COND_HI = 11;
    localparam int unsigned COND_LO = 9;

    typedef struct packed {
        logic [2:0] funsel;
        logic       lsp;
        logic       lpc;
        logic       lmdr;
        logic       lmar;
        logic       lisr;
        logic       ly;
        logic       wrr;
        logic       mrw;
        logic [2:0] rsel;
        logic       spmar;
        logic       pcmar;
        logic       mdrz;
        logic       mdrm;
        logic       tr;
        logic       tsp;
        logic       tpc;
        logic       tmdr;
        logic       tisr;
    } ctl_t;

    // Final execute step of each multi-step opcode; after it the FSM refetches.
    function automatic logic [STATE_W-1:0] last_step(input logic [3:0] op);
        case (op)
            OP_ALU, OP_JMP:          last_step = S_E1;
            OP_LOAD, OP_STORE:       last_step = S_E2;
            OP_PUSH, OP_RET, OP_POP: last_step = S_E3;
            OP_CALL:                 last_step = S_E5;
            default:                 last_step = S_E0;
        endcase
    endfunction

endpackage

// File: rtl/controller_cond_eval.sv
// Branch condition: selected status flag, optionally inverted by cond[2].
module cond_eval (
    input  logic [2:0] cond,
    input  logic [3:0] sreg,
    output logic       take
);

    assign take = sreg[cond[1:0]] ^ cond[2];

endmodule

// File: rtl/controller.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit CPU datapath.
// Control outputs are decoded combinationally from state, isr and sreg.
module controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] isr,
    input  logic [3:0]  sreg,
    output logic [2:0]  funsel,
    output logic        lsp,
    output logic        lpc,
    output logic        lmdr,
    output logic        lmar,
    output logic        lisr,
    output logic        ly,
    output logic        wrr,
    output logic        mrw,
    output logic [2:0]  rsel,
    output logic        spmar,
    output logic        pcmar,
    output logic        mdrz,
    output logic        mdrm,
    output logic        tr,
    output logic        tsp,
    output logic        tpc,
    output logic        tmdr,
    output logic        tisr
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [3:0]         op;
    logic [2:0]         rd;
    logic [2:0]         rs;
    logic [2:0]         f;
    logic               take;
    ctl_t               ctl;
    ctl_t               ctl_out;
    logic               unused_isr;

    assign op         = isr[OP_HI:OP_LO];
    assign rd         = isr[RD_HI:RD_LO];
    assign rs         = isr[RS_HI:RS_LO];
    assign f          = isr[F_HI:F_LO];
    assign unused_isr = ^isr[2:0];

    cond_eval u_cond_eval (
        .cond (isr[COND_HI:COND_LO]),
        .sreg (sreg),
        .take (take)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_F0;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctl        = '0;
        case (state)
            S_F0: begin
                ctl.pcmar  = 1'b1;
                ctl.lmar   = 1'b1;
                next_state = S_F1;
            end
            S_F1: begin
                ctl.mdrm   = 1'b1;
                ctl.lmdr   = 1'b1;
                ctl.tpc    = 1'b1;
                ctl.funsel = FN_INC;
                ctl.lpc    = 1'b1;
                next_state = S_F2;
            end
            // Branch outcome is committed here; execute steps never look at sreg.
            S_F2: begin
                ctl.tmdr   = 1'b1;
                ctl.lisr   = 1'b1;
                case (op)
                    OP_ALU, OP_LOAD, OP_STORE,
                    OP_PUSH, OP_RET, OP_POP:   next_state = S_E0;
                    OP_JMP, OP_CALL:           next_state = take ? S_E0 : S_F0;
                    default:                   next_state = S_F0;
                endcase
            end
            S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
                next_state = (state == last_step(op)) ? S_F0 : state + STATE_W'(1);
                case (op)
                    OP_ALU: begin
                        ctl.tr = 1'b1;
                        if (state == S_E0) begin
                            ctl.rsel = rs;
                            ctl.ly   = 1'b1;
                        end else begin
                            ctl.rsel   = rd;
                            ctl.funsel = f;
                            ctl.wrr    = 1'b1;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        case (state)
                            S_E0: begin
                                ctl.rsel = rs;
                                ctl.tr   = 1'b1;
                                ctl.lmar = 1'b1;
                            end
                            S_E1: begin
                                if (op == OP_LOAD) begin
                                    ctl.mdrm = 1'b1;
                                end else begin
                                    ctl.rsel = rd;
                                    ctl.tr   = 1'b1;
                                    ctl.mdrz = 1'b1;
                                end
                                ctl.lmdr = 1'b1;
                            end
                            default: begin
                                if (op == OP_LOAD) begin
                                    ctl.tmdr = 1'b1;
                                    ctl.rsel = rd;
                                    ctl.wrr  = 1'b1;
                                end else begin
                                    ctl.mrw = 1'b1;
                                end
                            end
                        endcase
                    end
                    OP_PUSH: begin
                        case (state)
                            S_E0: begin
                                ctl.tsp    = 1'b1;
                                ctl.funsel = FN_DEC;
                                ctl.lsp    = 1'b1;
                            end
                            S_E1: begin
                                ctl.spmar = 1'b1;
                                ctl.lmar  = 1'b1;
                            end
                            S_E2: begin
                                ctl.rsel = rd;
                                ctl.tr   = 1'b1;
                                ctl.mdrz = 1'b1;
                                ctl.lmdr = 1'b1;
                            end
                            default: ctl.mrw = 1'b1;
                        endcase
                    end
                    OP_RET, OP_POP: begin
                        case (state)
                            S_E0: begin
                                ctl.spmar = 1'b1;
                                ctl.lmar  = 1'b1;
                            end
                            S_E1: begin
                                ctl.mdrm = 1'b1;
                                ctl.lmdr = 1'b1;
                            end
                            S_E2: begin
                                ctl.tsp    = 1'b1;
                                ctl.funsel = FN_INC;
                                ctl.lsp    = 1'b1;
                            end
                            default: begin
                                ctl.tmdr = 1'b1;
                                if (op == OP_RET) begin
                                    ctl.lpc = 1'b1;
                                end else begin
                                    ctl.rsel = rd;
                                    ctl.wrr  = 1'b1;
                                end
                            end
                        endcase
                    end
                    OP_JMP: begin
                        if (state == S_E0) begin
                            ctl.tpc = 1'b1;
                            ctl.ly  = 1'b1;
                        end else begin
                            ctl.tisr   = 1'b1;
                            ctl.funsel = FN_ADD;
                            ctl.lpc    = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        case (state)
                            S_E0: begin
                                ctl.tsp    = 1'b1;
                                ctl.funsel = FN_DEC;
                                ctl.lsp    = 1'b1;
                            end
                            S_E1: begin
                                ctl.spmar = 1'b1;
                                ctl.lmar  = 1'b1;
                            end
                            S_E2: begin
                                ctl.tpc  = 1'b1;
                                ctl.mdrz = 1'b1;
                                ctl.lmdr = 1'b1;
                            end
                            S_E3: ctl.mrw = 1'b1;
                            S_E4: begin
                                ctl.tpc = 1'b1;
                                ctl.ly  = 1'b1;
                            end
                            default: begin
                                ctl.tisr   = 1'b1;
                                ctl.funsel = FN_ADD;
                                ctl.lpc    = 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            default: next_state = S_F0;
        endcase
    end

    // Reset blanks every strobe at once so an aborted instruction cannot write.
    assign ctl_out = reset ? ctl : '0;

    assign funsel = ctl_out.funsel;
    assign lsp    = ctl_out.lsp;
    assign lpc    = ctl_out.lpc;
    assign lmdr   = ctl_out.lmdr;
    assign lmar   = ctl_out.lmar;
    assign lisr   = ctl_out.lisr;
    assign ly     = ctl_out.ly;
    assign wrr    = ctl_out.wrr;
    assign mrw    = ctl_out.mrw;
    assign rsel   = ctl_out.rsel;
    assign spmar  = ctl_out.spmar;
    assign pcmar  = ctl_out.pcmar;
    assign mdrz   = ctl_out.mdrz;
    assign mdrm   = ctl_out.mdrm;
    assign tr     = ctl_out.tr;
    assign tsp    = ctl_out.tsp;
    assign tpc    = ctl_out.tpc;
    assign tmdr   = ctl_out.tmdr;
    assign tisr   = ctl_out.tisr;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed instruction table, reset abort
// sequence and random instructions against a step-list reference model.
module tb_controller;

    typedef struct packed {
        logic [2:0] funsel;
        logic       lsp, lpc, lmdr, lmar, lisr, ly, wrr, mrw;
        logic [2:0] rsel;
        logic       spmar, pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr;
    } word_t;

    typedef struct {
        logic [15:0] iv;
        logic [3:0]  sv;
        int          cyc;
        int          nwrr;
        int          nmrw;
        int          nlpc;
        string       name;
    } vec_t;

    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] INC = 3'b110;
    localparam logic [2:0] DEC = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] isr;
    logic [3:0]  sreg;
    logic [2:0]  funsel, rsel;
    logic        lsp, lpc, lmdr, lmar, lisr, ly, wrr, mrw;
    logic        spmar, pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr;
    word_t       act;

    int checks   = 0;
    int failures = 0;
    int n_wrr, n_mrw, n_lpc;
    word_t exp_q[$];
    vec_t  vecs[12];

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .reset(reset), .isr(isr), .sreg(sreg),
        .funsel(funsel), .lsp(lsp), .lpc(lpc), .lmdr(lmdr), .lmar(lmar),
        .lisr(lisr), .ly(ly), .wrr(wrr), .mrw(mrw), .rsel(rsel),
        .spmar(spmar), .pcmar(pcmar), .mdrz(mdrz), .mdrm(mdrm),
        .tr(tr), .tsp(tsp), .tpc(tpc), .tmdr(tmdr), .tisr(tisr)
    );

    assign act = {funsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr, mrw, rsel,
                  spmar, pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic invariants(input string tag);
        check({tag, " bus_drivers"}, 32'(($countones({tr, tsp, tpc, tmdr, tisr}) <= 1)), 32'd1);
        check({tag, " mrw_mdrm"}, 32'(mrw & mdrm), 32'd0);
    endtask

    // Reference: the instruction's cycle-by-cycle step list, written from the op table.
    function automatic void build_exp(input logic [15:0] iv, input logic [3:0] sv);
        word_t s;
        logic [3:0] op;
        logic [2:0] rd, rs, f;
        logic [1:0] ci;
        logic take;
        op = iv[15:12]; rd = iv[11:9]; rs = iv[8:6]; f = iv[5:3]; ci = iv[10:9];
        take = sv[ci] ^ iv[11];
        exp_q.delete();
        s = '0; s.pcmar = 1; s.lmar = 1; exp_q.push_back(s);
        s = '0; s.mdrm = 1; s.lmdr = 1; s.tpc = 1; s.funsel = INC; s.lpc = 1; exp_q.push_back(s);
        s = '0; s.tmdr = 1; s.lisr = 1; exp_q.push_back(s);
        case (op)
            4'b0000: begin
                s = '0; s.rsel = rs; s.tr = 1; s.ly = 1; exp_q.push_back(s);
                s = '0; s.rsel = rd; s.tr = 1; s.funsel = f; s.wrr = 1; exp_q.push_back(s);
            end
            4'b0110, 4'b0111: begin
                s = '0; s.rsel = rs; s.tr = 1; s.lmar = 1; exp_q.push_back(s);
                if (op == 4'b0110) begin
                    s = '0; s.mdrm = 1; s.lmdr = 1; exp_q.push_back(s);
                    s = '0; s.tmdr = 1; s.rsel = rd; s.wrr = 1; exp_q.push_back(s);
                end else begin
                    s = '0; s.rsel = rd; s.tr = 1; s.mdrz = 1; s.lmdr = 1; exp_q.push_back(s);
                    s = '0; s.mrw = 1; exp_q.push_back(s);
                end
            end
            4'b1001: begin
                s = '0; s.tsp = 1; s.funsel = DEC; s.lsp = 1; exp_q.push_back(s);
                s = '0; s.spmar = 1; s.lmar = 1; exp_q.push_back(s);
                s = '0; s.rsel = rd; s.tr = 1; s.mdrz = 1; s.lmdr = 1; exp_q.push_back(s);
                s = '0; s.mrw = 1; exp_q.push_back(s);
            end
            4'b1010, 4'b1011: begin
                s = '0; s.spmar = 1; s.lmar = 1; exp_q.push_back(s);
                s = '0; s.mdrm = 1; s.lmdr = 1; exp_q.push_back(s);
                s = '0; s.tsp = 1; s.funsel = INC; s.lsp = 1; exp_q.push_back(s);
                s = '0; s.tmdr = 1;
                if (op == 4'b1010) s.lpc = 1;
                else begin s.rsel = rd; s.wrr = 1; end
                exp_q.push_back(s);
            end
            4'b1100: if (take) begin
                s = '0; s.tpc = 1; s.ly = 1; exp_q.push_back(s);
                s = '0; s.tisr = 1; s.funsel = ADD; s.lpc = 1; exp_q.push_back(s);
            end
            4'b1101: if (take) begin
                s = '0; s.tsp = 1; s.funsel = DEC; s.lsp = 1; exp_q.push_back(s);
                s = '0; s.spmar = 1; s.lmar = 1; exp_q.push_back(s);
                s = '0; s.tpc = 1; s.mdrz = 1; s.lmdr = 1; exp_q.push_back(s);
                s = '0; s.mrw = 1; exp_q.push_back(s);
                s = '0; s.tpc = 1; s.ly = 1; exp_q.push_back(s);
                s = '0; s.tisr = 1; s.funsel = ADD; s.lpc = 1; exp_q.push_back(s);
            end
            default: ;
        endcase
    endfunction

    // Entered just after a posedge in F0; runs n cycles, then checks the return to F0.
    task automatic run_instr(input logic [15:0] iv, input logic [3:0] sv, input int n, input string tag);
        isr = iv; sreg = sv;
        build_exp(iv, sv);
        n_wrr = 0; n_mrw = 0; n_lpc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i < exp_q.size()) check($sformatf("%s step%0d", tag, i), 32'(act), 32'(exp_q[i]));
            invariants(tag);
            n_wrr += int'(wrr); n_mrw += int'(mrw); n_lpc += int'(lpc);
            @(posedge clk); #1;
            if (i == 2) sreg = 4'($urandom);
        end
        check({tag, " back_to_f0"}, 32'({pcmar, lmar, lpc, lisr}), 32'b1100);
    endtask

    initial begin
        vecs[0]  = '{16'hC200, 4'b0000, 3, 0, 0, 1, "jmp_not_taken"};
        vecs[1]  = '{16'hDA00, 4'b0000, 9, 0, 1, 2, "call_taken"};
        vecs[2]  = '{16'h00F0, 4'b0000, 5, 1, 0, 1, "alu_inc"};
        vecs[3]  = '{16'hA000, 4'b0000, 7, 0, 0, 2, "ret"};
        vecs[4]  = '{16'h6440, 4'b1010, 6, 1, 0, 1, "load"};
        vecs[5]  = '{16'h7700, 4'b0101, 6, 0, 1, 1, "store"};
        vecs[6]  = '{16'h90F0, 4'b0000, 7, 0, 1, 1, "push"};
        vecs[7]  = '{16'hBC00, 4'b1111, 7, 1, 0, 1, "pop"};
        vecs[8]  = '{16'hC1FF, 4'b0001, 5, 0, 0, 2, "jmp_z_taken"};
        vecs[9]  = '{16'hDC00, 4'b0100, 3, 0, 0, 1, "call_notn_false"};
        vecs[10] = '{16'h3FFF, 4'b1111, 3, 0, 0, 1, "nop"};
        vecs[11] = '{16'hCE00, 4'b0000, 5, 0, 0, 2, "jmp_notv_taken"};

        reset = 1'b0; isr = 16'hD000; sreg = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_zero c%0d", i), 32'(act), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (vecs[k]) begin
            run_instr(vecs[k].iv, vecs[k].sv, vecs[k].cyc, vecs[k].name);
            check({vecs[k].name, " wrr_pulses"}, 32'(n_wrr), 32'(vecs[k].nwrr));
            check({vecs[k].name, " mrw_pulses"}, 32'(n_mrw), 32'(vecs[k].nmrw));
            check({vecs[k].name, " lpc_pulses"}, 32'(n_lpc), 32'(vecs[k].nlpc));
        end

        // PUSH aborted by reset in E2: strobes drop immediately, no store follows.
        isr = 16'h90F0; sreg = 4'h0;
        build_exp(isr, sreg);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("push_abort step%0d", i), 32'(act), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
        check("push_abort e2_before_reset", 32'(act), 32'(exp_q[5]));
        reset = 1'b0; #1;
        check("push_abort outputs_zero_now", 32'(act), 32'd0);
        @(posedge clk); #1;
        check("push_abort no_write_after", 32'(mrw), 32'd0);
        @(negedge clk);
        check("push_abort still_zero", 32'(act), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; #1;
        check("push_abort restart_pcmar", 32'({pcmar, lmar}), 32'b11);
        run_instr(16'h00F0, 4'h0, 5, "after_abort_alu");

        for (int r = 0; r < 300; r++) begin
            logic [15:0] iv;
            logic [3:0]  sv;
            iv = 16'($urandom);
            sv = 4'($urandom);
            build_exp(iv, sv);
            run_instr(iv, sv, exp_q.size(), $sformatf("rand%0d_isr%h_sreg%h", r, iv, sv));
            if (iv[15:12] == 4'b0000 || iv[15:12] == 4'b0110 || iv[15:12] == 4'b1011)
                check($sformatf("rand%0d wrr_once", r), 32'(n_wrr), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
